fir_out_requant: RTL and testbench

//  Output stage directly downstream of fir_filter. Consumes the 32-bit Q2.30 y_out/y_valid stream,

---
 rtl/fir_out_requant.sv | 142 ++++++++++++++
 tb/tb_fir_out_requant.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_requant.sv
// fir_out_requant: rounds and saturates the Q2.30 fir_filter stream to Q1.15.
// The result is buffered in a show-ahead FIFO that has a valid/ready output.
// The upstream filter cannot stall, so a sample that arrives while the FIFO is
// full is dropped and counted. Saturation and drop statistics are exposed.
//
// Output handshake: out_valid is high whenever the FIFO holds at least one
// entry, and out_data is then the head entry. An entry is consumed on a rising
// edge where out_valid && out_ready. out_valid does not depend on out_ready.
// While out_valid && !out_ready, out_data holds its value.
module fir_out_requant #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IN_W-1:0]            y_in,
  input  logic                       y_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [CNT_W-1:0]           sat_cnt,
  input  logic                       stats_clr
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  // Width of the rounded value: IN_W+1 bits after the shift by SHIFT.
  localparam int R_W   = IN_W + 1 - SHIFT;
  localparam logic [IN_W:0]       HALF    = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [OUT_W-1:0]    OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]    OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [LVL_W-1:0]    LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  // Stage 1: sign-extend by one bit so that adding the rounding half cannot
  // wrap at the most positive input. The arithmetic shift is a bit slice.
  logic [IN_W:0]  sum;
  logic [R_W-1:0] r1;
  logic           v1;

  assign sum = {y_in[IN_W-1], y_in} + HALF;

  // S1 register: rounded value and its valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1 <= '0;
      v1 <= 1'b0;
    end else begin
      r1 <= sum[IN_W:SHIFT];
      v1 <= y_valid;
    end
  end

  // Stage 2: r1 fits OUT_W bits only if every bit above the output sign bit
  // equals that sign bit. Otherwise clip toward the sign of r1.
  logic [R_W-OUT_W:0] hi_bits;
  logic               in_range;
  logic [OUT_W-1:0]   clip;
  logic [OUT_W-1:0]   d2;
  logic               sat2;
  logic               v2;

  assign hi_bits  = r1[R_W-1:OUT_W-1];
  assign in_range = (&hi_bits) | (~|hi_bits);
  assign clip     = in_range ? r1[OUT_W-1:0] : (r1[R_W-1] ? OUT_MIN : OUT_MAX);

  // S2 register: clipped sample, saturation flag and valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d2   <= '0;
      sat2 <= 1'b0;
      v2   <= 1'b0;
    end else begin
      d2   <= clip;
      sat2 <= !in_range;
      v2   <= v1;
    end
  end

  // FIFO: at full, a write is accepted only when a pop happens on the same edge.
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic             push;
  logic             drop;

  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign push      = v2 && ((level != LVL_FULL) || pop);
  assign drop      = v2 && !push;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Storage write. The array is not reset because entries are read only
  // while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= d2;
    end
  end

  // Pointer and occupancy update. The pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Statistics. An event in the same cycle as stats_clr wins over the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
      sat_cnt  <= '0;
    end else if (stats_clr) begin
      overflow <= drop;
      drop_cnt <= drop ? CNT_W'(1) : '0;
      sat_cnt  <= (v2 && sat2) ? CNT_W'(1) : '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (drop && drop_cnt != CNT_MAX)          drop_cnt <= drop_cnt + 1'b1;
      if (v2 && sat2 && sat_cnt != CNT_MAX)     sat_cnt  <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: a vector table for rounding and
// saturation, plus hand-written sequences for latency, overflow, a write and
// a pop on the same edge at full, and reset while samples are in flight.
module tb_fir_out_requant;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] y_in;
  logic        y_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [15:0] sat_cnt;
  logic        stats_clr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [31:0] y;
    logic [15:0] exp_data;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[7];

  fir_out_requant dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .y_in      (y_in),
    .y_valid   (y_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .sat_cnt   (sat_cnt),
    .stats_clr (stats_clr)
  );

  // Clock and a global watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // All inputs are driven and all outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h", name, act, exp);
    end
  endtask

  // Send one sample with out_ready high, wait (bounded) for it, and check it.
  task automatic send_and_check(input string name, input logic [31:0] y, input logic [15:0] exp);
    bit found = 0;
    y_in = y; y_valid = 1'b1;
    tick();
    y_valid = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (out_valid) begin
        found = 1;
        chk(name, 32'(out_data), 32'(exp));
      end else begin
        tick();
      end
    end
    if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
    tick();
  endtask

  task automatic clear_stats();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_sat;
    logic [15:0] v;
    vecs[0] = '{32'd16384,               16'd1,      1'b0};
    vecs[1] = '{32'd16383,               16'd0,      1'b0};
    vecs[2] = '{-32'sd16384,             16'd0,      1'b0};
    vecs[3] = '{-32'sd16385,             16'hFFFF,   1'b0};
    vecs[4] = '{32'h7FFF_FFFF,           16'h7FFF,   1'b1};
    vecs[5] = '{32'h8000_0000,           16'h8000,   1'b1};
    vecs[6] = '{32'd1073709056,          16'h7FFF,   1'b0};

    // Reset.
    rst_n = 1'b0; y_in = '0; y_valid = 1'b0; out_ready = 1'b1; stats_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    chk("rst_sat_cnt",   32'(sat_cnt),   32'd0);

    // Rounding and saturation table.
    exp_sat = '0;
    for (int i = 0; i < 7; i++) begin
      send_and_check($sformatf("vec%0d_data", i), vecs[i].y, vecs[i].exp_data);
      exp_sat += 16'(vecs[i].exp_sat);
      chk($sformatf("vec%0d_sat_cnt", i), 32'(sat_cnt), 32'(exp_sat));
    end

    // Latency: a pulse sampled at edge 0 is visible after edge 2, for one cycle.
    tick();
    y_in = 32'(5) << 15; y_valid = 1'b1;
    tick(); y_valid = 1'b0;
    chk("lat_e0_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_e1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_e2_valid", 32'(out_valid), 32'd1);
    chk("lat_e2_data",  32'(out_data),  32'd5);
    tick();
    chk("lat_e3_valid", 32'(out_valid), 32'd0);

    // Overflow: 20 back-to-back samples into a stalled FIFO.
    clear_stats();
    out_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      y_in = 32'(k) << 15; y_valid = 1'b1;
      tick();
    end
    y_valid = 1'b0;
    tick(); tick(); tick();
    chk("ovf_level",    32'(level),    32'd16);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
    chk("ovf_flag",     32'(overflow), 32'd1);
    chk("ovf_sat_cnt",  32'(sat_cnt),  32'd0);
    chk("ovf_hold_data", 32'(out_data), 32'd1);
    tick();
    chk("ovf_hold_data2", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d_data", k),  32'(out_data),  32'(k));
      tick();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
    clear_stats();
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("clr_sat_cnt",  32'(sat_cnt),  32'd0);

    // Full with pop: fill to 16, then a write and a pop on every edge.
    out_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      y_in = 32'(k) << 15; y_valid = 1'b1;
      exp_q.push_back(16'(k));
      tick();
    end
    y_valid = 1'b0;
    tick(); tick(); tick();
    chk("fp_fill_level", 32'(level), 32'd16);
    for (int i = 0; i < 12; i++) begin
      if (i >= 2) out_ready = 1'b1;
      if (out_ready && out_valid) begin
        v = exp_q.pop_front();
        chk($sformatf("fp_stream%0d_data", i), 32'(out_data), 32'(v));
      end
      chk($sformatf("fp_stream%0d_level", i), 32'(level), 32'd16);
      y_in = 32'(17 + i) << 15; y_valid = 1'b1;
      exp_q.push_back(16'(17 + i));
      tick();
    end
    y_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      if (out_valid) begin
        v = exp_q.pop_front();
        chk("fp_drain_data", 32'(out_data), 32'(v));
      end
      tick();
    end
    chk("fp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("fp_drop_cnt",    32'(drop_cnt),     32'd0);
    chk("fp_out_empty",   32'(out_valid),    32'd0);

    // Reset mid-stream: 8 saturating entries, 2 samples in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      y_in = 32'h7FFF_FFFF; y_valid = 1'b1;
      tick();
    end
    y_valid = 1'b0;
    tick(); tick(); tick();
    chk("mr_level",   32'(level),   32'd8);
    chk("mr_sat_cnt", 32'(sat_cnt), 32'd8);
    y_in = 32'(3) << 15; y_valid = 1'b1;
    tick();
    y_in = 32'(4) << 15;
    tick();
    y_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_level0",    32'(level),     32'd0);
    chk("mr_sat0",      32'(sat_cnt),   32'd0);
    chk("mr_drop0",     32'(drop_cnt),  32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("mr_quiet%0d_valid", i), 32'(out_valid), 32'd0);
    end
    chk("mr_quiet_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
